// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//
// Parametrised multi-read-port integer register file with a built-in
// pending-write scoreboard. Each architectural register has a busy bit.
// Decode sets the bit when it issues a producer (reserve), and writeback
// clears it. Decode can then stall on RAW hazards directly from read_busy.
// Register 0 is hardwired to zero and is never busy.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   Defined   : a read port whose index matches an active write forwards
//               write_data in the same cycle. Its busy flag is 0, unless the
//               same index is also reserved in that cycle.
//   Undefined : reads return only the stored value and the registered busy bit.
//
// Parameters:
//   DATA_WIDTH - width of each register
//   ADDR_WIDTH - register index width; depth = 2**ADDR_WIDTH
//   NUM_READ   - number of independent read ports (1..4)
//
// Ports:
//   clk            - clock; all state updates on rising edge
//   reset          - synchronous, active-high; clears data, busy bits, count
//   write_enable   - writeback strobe
//   write_reg      - writeback destination index
//   write_data     - writeback value
//   reserve_enable - issue strobe; marks reserve_reg as pending
//   reserve_reg    - index to mark busy
//   read_reg       - flattened read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   read_data      - flattened read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   read_busy      - per-port outstanding-producer flag
//   busy_count     - registered number of busy registers

module regfile_scoreboard #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_READ   = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           write_enable,
   input  logic [ADDR_WIDTH-1:0]          write_reg,
   input  logic [DATA_WIDTH-1:0]          write_data,
   input  logic                           reserve_enable,
   input  logic [ADDR_WIDTH-1:0]          reserve_reg,
   input  logic [NUM_READ*ADDR_WIDTH-1:0] read_reg,
   output logic [NUM_READ*DATA_WIDTH-1:0] read_data,
   output logic [NUM_READ-1:0]            read_busy,
   output logic [ADDR_WIDTH:0]            busy_count
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic [DEPTH-1:0]      busy;
   logic [DEPTH-1:0]      busy_next;
   logic [ADDR_WIDTH:0]   busy_count_next;
   logic                  write_valid;
   logic                  reserve_valid;

   // Index 0 accepts neither writes nor reservations.
   assign write_valid   = write_enable   && (write_reg   != '0);
   assign reserve_valid = reserve_enable && (reserve_reg != '0);

   // The busy update is applied in two steps. The writeback clear comes first,
   // then the reserve set. This ordering means a same-index reserve wins
   // (a new producer supersedes the one that is retiring). busy_count is the
   // popcount of the next busy vector, so the count is registered on the
   // same edge as busy.
   always_comb begin
      // NOTE: every variable gets a default before any conditional update,
      // so no path leaves it unassigned and no latch is inferred.
      busy_next       = busy;
      busy_count_next = '0;
      if (write_valid)
         busy_next[write_reg] = 1'b0;
      if (reserve_valid)
         busy_next[reserve_reg] = 1'b1;
      busy_next[0] = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         busy_count_next = busy_count_next + {{ADDR_WIDTH{1'b0}}, busy_next[i]};
   end

   always_ff @(posedge clk) begin
      // NOTE: the data array is cleared by reset as well, not only the busy
      // bits. No register value may survive a reset. This makes the array
      // flops rather than a RAM macro.
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            regs[i] <= '0;
         busy       <= '0;
         busy_count <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments only, so every
         // read in this block sees the pre-edge value.
         if (write_valid)
            regs[write_reg] <= write_data;
         busy       <= busy_next;
         busy_count <= busy_count_next;
      end
   end

   // Independent combinational read ports; any number may alias one index.
   for (genvar p = 0; p < NUM_READ; p++) begin : g_read
      logic [ADDR_WIDTH-1:0] idx;
      logic [DATA_WIDTH-1:0] port_data;
      logic                  port_busy;

      assign idx = read_reg[p*ADDR_WIDTH +: ADDR_WIDTH];

      always_comb begin
         port_data = regs[idx];
         port_busy = busy[idx];
         if (idx == '0) begin
            port_data = '0;
            port_busy = 1'b0;
         end
`ifdef REGFILE_BYPASS_EN
         else if (write_enable && (write_reg == idx)) begin
            port_data = write_data;
            port_busy = reserve_enable && (reserve_reg == idx);
         end
`endif
      end

      assign read_data[p*DATA_WIDTH +: DATA_WIDTH] = port_data;
      assign read_busy[p]                          = port_busy;
   end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard
//
// Directed testbench for regfile_scoreboard with the default parameters
// (32-bit data, 32 registers, 2 read ports). The inputs change 1 time unit
// after each rising edge. The outputs are sampled before the next edge.

module tb_regfile_scoreboard;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 2;

   logic             clk = 1'b0;
   logic             reset;
   logic             write_enable;
   logic [AW-1:0]    write_reg;
   logic [DW-1:0]    write_data;
   logic             reserve_enable;
   logic [AW-1:0]    reserve_reg;
   logic [NR*AW-1:0] read_reg;
   logic [NR*DW-1:0] read_data;
   logic [NR-1:0]    read_busy;
   logic [AW:0]      busy_count;

   int vectors     = 0;
   int miscompares = 0;

   regfile_scoreboard #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_READ(NR)) dut (
      .clk            (clk),
      .reset          (reset),
      .write_enable   (write_enable),
      .write_reg      (write_reg),
      .write_data     (write_data),
      .reserve_enable (reserve_enable),
      .reserve_reg    (reserve_reg),
      .read_reg       (read_reg),
      .read_data      (read_data),
      .read_busy      (read_busy),
      .busy_count     (busy_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_reads(input logic [AW-1:0] p0, input logic [AW-1:0] p1);
      read_reg = {p1, p0};
      #1;
   endtask

   task automatic idle();
      write_enable   = 1'b0;
      reserve_enable = 1'b0;
   endtask

   task automatic test_reset();
      logic [AW-1:0] pairs [2][2];
      pairs[0][0] = 5'd5;  pairs[0][1] = 5'd31;
      pairs[1][0] = 5'd31; pairs[1][1] = 5'd5;
      for (int k = 0; k < 2; k++) begin
         set_reads(pairs[k][0], pairs[k][1]);
         vectors++;
         if (read_data !== 64'h0) begin
            miscompares++;
            $display("FAIL reset_data[%0d]: got %h expected 0", k, read_data);
         end
         vectors++;
         if (read_busy !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_busy[%0d]: got %b expected 00", k, read_busy);
         end
      end
      vectors++;
      if (busy_count !== 6'd0) begin
         miscompares++;
         $display("FAIL reset_count: got %0d expected 0", busy_count);
      end
   endtask

   task automatic test_reserve_write();
      reserve_enable = 1'b1; reserve_reg = 5'd5;
      tick();
      idle();
      set_reads(5'd5, 5'd5);
      vectors++;
      if (read_busy !== 2'b11) begin
         miscompares++;
         $display("FAIL reserve_busy: got %b expected 11", read_busy);
      end
      vectors++;
      if (busy_count !== 6'd1) begin
         miscompares++;
         $display("FAIL reserve_count: got %0d expected 1", busy_count);
      end
      write_enable = 1'b1; write_reg = 5'd5; write_data = 32'hA5A5_A5A5;
      tick();
      idle();
      #1;
      vectors++;
      if (read_data !== {2{32'hA5A5_A5A5}}) begin
         miscompares++;
         $display("FAIL write_data_x5: got %h expected a5a5a5a5a5a5a5a5", read_data);
      end
      vectors++;
      if (read_busy !== 2'b00 || busy_count !== 6'd0) begin
         miscompares++;
         $display("FAIL write_clear_x5: got busy=%b count=%0d expected busy=00 count=0",
                  read_busy, busy_count);
      end
   endtask

   task automatic test_zero_reg();
      write_enable = 1'b1;   write_reg = 5'd0; write_data = 32'hDEAD_BEEF;
      reserve_enable = 1'b1; reserve_reg = 5'd0;
      tick();
      idle();
      set_reads(5'd0, 5'd0);
      vectors++;
      if (read_data !== 64'h0 || read_busy !== 2'b00 || busy_count !== 6'd0) begin
         miscompares++;
         $display("FAIL x0_hardwired: got data=%h busy=%b count=%0d expected 0/00/0",
                  read_data, read_busy, busy_count);
      end
   endtask

   task automatic test_same_cycle();
      // Reserve and write the same index: the data lands and busy stays set.
      write_enable = 1'b1;   write_reg = 5'd3; write_data = 32'h1234_5678;
      reserve_enable = 1'b1; reserve_reg = 5'd3;
      tick();
      idle();
      set_reads(5'd3, 5'd5);
      vectors++;
      if (read_data[31:0] !== 32'h1234_5678 || read_busy !== 2'b01 || busy_count !== 6'd1) begin
         miscompares++;
         $display("FAIL same_idx: got data=%h busy=%b count=%0d expected 12345678/01/1",
                  read_data[31:0], read_busy, busy_count);
      end
      // Write strobe low: x4 must not change.
      write_enable = 1'b0; write_reg = 5'd4; write_data = 32'h8765_4321;
      tick();
      set_reads(5'd4, 5'd3);
      vectors++;
      if (read_data[31:0] !== 32'h0) begin
         miscompares++;
         $display("FAIL we_low_x4: got %h expected 0", read_data[31:0]);
      end
      // Write x3 and reserve x6 in the same cycle: both take effect.
      write_enable = 1'b1;   write_reg = 5'd3; write_data = 32'h1111_2222;
      reserve_enable = 1'b1; reserve_reg = 5'd6;
      tick();
      idle();
      set_reads(5'd3, 5'd6);
      vectors++;
      if (read_data !== {32'h0, 32'h1111_2222} || read_busy !== 2'b10 || busy_count !== 6'd1) begin
         miscompares++;
         $display("FAIL diff_idx: got data=%h busy=%b count=%0d expected 0000000011112222/10/1",
                  read_data, read_busy, busy_count);
      end
   endtask

   task automatic test_bypass();
      logic [DW-1:0] same_cycle_exp;
`ifdef REGFILE_BYPASS_EN
      same_cycle_exp = 32'hAAAA_5555;
`else
      same_cycle_exp = 32'h0;
`endif
      set_reads(5'd3, 5'd10);
      write_enable = 1'b1; write_reg = 5'd10; write_data = 32'hAAAA_5555;
      #1;
      vectors++;
      if (read_data[63:32] !== same_cycle_exp || read_busy[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL bypass_same_cycle: got data=%h busy=%b expected %h/0",
                  read_data[63:32], read_busy[1], same_cycle_exp);
      end
      vectors++;
      if (read_data[31:0] !== 32'h1111_2222) begin
         miscompares++;
         $display("FAIL bypass_other_port: got %h expected 11112222", read_data[31:0]);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (read_data[63:32] !== 32'hAAAA_5555) begin
         miscompares++;
         $display("FAIL bypass_next_cycle: got %h expected aaaa5555", read_data[63:32]);
      end
   endtask

   task automatic test_reset_midstream();
      // x6 is already busy from the earlier test, and reserving it again keeps
      // it counted once. So x1..x7 gives a count of exactly 7.
      reserve_enable = 1'b1;
      for (int r = 1; r <= 7; r++) begin
         reserve_reg = AW'(r);
         tick();
      end
      idle();
      #1;
      vectors++;
      if (busy_count !== 6'd7) begin
         miscompares++;
         $display("FAIL count_before_reset: got %0d expected 7", busy_count);
      end
      // Strobes asserted during reset must be ignored.
      reset = 1'b1;
      write_enable = 1'b1;   write_reg = 5'd9; write_data = 32'h5A5A_5A5A;
      reserve_enable = 1'b1; reserve_reg = 5'd9;
      tick();
      reset = 1'b0;
      idle();
      #1;
      vectors++;
      if (busy_count !== 6'd0) begin
         miscompares++;
         $display("FAIL count_after_reset: got %0d expected 0", busy_count);
      end
      begin
         logic [AW-1:0] idx [4];
         idx[0] = 5'd3; idx[1] = 5'd5; idx[2] = 5'd10; idx[3] = 5'd9;
         for (int k = 0; k < 4; k++) begin
            set_reads(idx[k], 5'd6);
            vectors++;
            if (read_data !== 64'h0 || read_busy !== 2'b00) begin
               miscompares++;
               $display("FAIL post_reset_x%0d: got data=%h busy=%b expected 0/00",
                        idx[k], read_data, read_busy);
            end
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      idle();
      write_reg = '0; write_data = '0; reserve_reg = '0; read_reg = '0;
      repeat (10) tick();
      reset = 1'b0;
      test_reset();
      test_reserve_write();
      test_zero_reg();
      test_same_cycle();
      test_bypass();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-read-port integer register file with a built-in pending-write scoreboard, serving as the next-generation register file of the core's decode/writeback stages. It generalises data width, register count and read-port count. It also tracks which architectural registers have an in-flight producer, so that decode can stall on RAW hazards without a separate scoreboard block. Register 0 is hardwired to zero.

## Interface
Parameters:
- `DATA_WIDTH`, 32, width of each register
- `ADDR_WIDTH`, 5, register index width; depth = 2**ADDR_WIDTH
- `NUM_READ`, 2, number of independent read ports (1..4)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears all registers and all busy bits
- `write_enable`  in  1  writeback strobe
- `write_reg`  in  ADDR_WIDTH  writeback destination index
- `write_data`  in  DATA_WIDTH  writeback value
- `reserve_enable`  in  1  issue strobe; marks destination as pending
- `reserve_reg`  in  ADDR_WIDTH  index to mark busy
- `read_reg`  in  NUM_READ*ADDR_WIDTH  flattened read indices; port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- `read_data`  out  NUM_READ*DATA_WIDTH  flattened read data; port i at [i*DATA_WIDTH +: DATA_WIDTH]
- `read_busy`  out  NUM_READ  1 = port i's register has an outstanding producer
- `busy_count`  out  ADDR_WIDTH+1  number of registers currently busy

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH registers plus busy vector of same depth; busy[0] is constant 0.
- Write: on edge with `write_enable`=1 and `write_reg`!=0, register takes `write_data`; busy[write_reg] clears. Write to index 0 is discarded.
- Write to a non-busy register: data updates; busy is unchanged (stays 0).
- Reserve: on edge with `reserve_enable`=1 and `reserve_reg`!=0, busy[reserve_reg] sets. Reserving an already-busy register keeps it busy; the count is unchanged.
- Reserve and write to the same index in the same cycle: data is written, busy ends 1 (the new producer wins).
- Reserve and write to different indices in the same cycle: both take effect.
- Reads: combinational. Index 0 returns 0 and `read_busy`=0. All ports are independent and may alias the same index.
- `busy_count` is the registered popcount of the busy vector and is updated on the same edge as busy.
- Reset: on any edge with `reset`=1, all data goes to 0, all busy to 0 and `busy_count` to 0. `write_enable` and `reserve_enable` are ignored that cycle.

## Timing
- Read latency: 0 cycles (combinational from `read_reg` and state).
- A write is visible on `read_data` the cycle after the write edge. With `REGFILE_BYPASS_EN`, it is visible in the same cycle (see Configuration).
- A reserve shows on `read_busy` and `busy_count` one cycle after the reserve edge.
- Reset values:
  - `read_data` = 0 on all ports.
  - `read_busy` = 0.
  - `busy_count` = 0.
- A reset asserted mid-stream with 7 busy registers drops `busy_count` to 0 on the next edge. No partial state survives.

## Configuration
- Macro `REGFILE_BYPASS_EN`.
- Defined: read port i forwards in the same cycle when all of the following hold: `write_enable`=1, `write_reg`==port index, and index!=0. In that case:
  - `read_data` = `write_data`.
  - `read_busy`=0, unless `reserve_enable` targets the same index that cycle, in which case `read_busy`=1.
- Undefined: there is no forwarding. Reads return the stored value and the registered busy bit only.

## Test plan
- Reset for 10 cycles, release; read x5 and x31 on both ports -> `read_data`=0, `read_busy`=0, `busy_count`=0.
- Reserve x5, next cycle read x5 -> `read_busy`=1, `busy_count`=1. Write x5=A5A5A5A5, next cycle -> `read_data`=A5A5A5A5, `read_busy`=0, `busy_count`=0.
- Write x0=DEADBEEF with `reserve_enable` on x0 -> x0 reads 0, `read_busy`=0, `busy_count`=0.
- Reserve x3 and write x3=12345678 in the same cycle -> next cycle x3 reads 12345678, `read_busy`=1, `busy_count`=1. Write x4=87654321 with `write_enable`=0 -> x4 stays 0.
- With `REGFILE_BYPASS_EN`: write x10=AAAA5555 while port 1 reads x10 in the same cycle -> `read_data[1]`=AAAA5555 that cycle. Without the macro -> old value (0) that cycle, AAAA5555 the next.
- Reserve x1..x7 on consecutive cycles, then assert reset for 1 cycle -> `busy_count` goes 7 -> 0. All reads return 0 after release.
